// File: rtl/cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_rr_arbiter
//  Description : Round-robin arbiter and output register for the common data
//                bus. Grants at most one functional-unit result per cycle
//                (one-hot, combinational req_ready) and registers the
//                winner's tag, data and index for a one-cycle broadcast.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_rr_arbiter #(
    parameter int N_REQ  = 4,     // number of requesters, >= 2 and a power of two
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*TAG_W-1:0]     req_tag,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(N_REQ)-1:0]   cdb_src
);

    localparam int SRC_W = $clog2(N_REQ);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [SRC_W-1:0]   r_prio_ptr;
    logic               r_cdb_valid;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [DATA_W-1:0]  r_cdb_data;
    logic [SRC_W-1:0]   r_cdb_src;

    // ------------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------------
    logic               w_any;
    logic [SRC_W-1:0]   w_win;
    logic               w_xfer;
    logic [TAG_W-1:0]   w_tag_arr  [N_REQ];
    logic [DATA_W-1:0]  w_data_arr [N_REQ];

    // Unpack the flat request buses so the winner can be selected by index.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_tag_arr[gi]  = req_tag[gi*TAG_W +: TAG_W];
            assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Search from the priority pointer upwards with wrap-around. Scanning
    // offsets from the far end down lets the nearest valid requester be the
    // last assignment, so no separate "found" flag is needed. Index addition
    // wraps naturally because N_REQ is a power of two.
    always_comb begin
        logic [SRC_W-1:0] w_idx;
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = r_prio_ptr + SRC_W'(k);
            if (req_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // A transfer happens only when the bus is free and not being flushed;
    // grants are also suppressed while reset is held.
    assign w_xfer = w_any & ~stall & ~flush & ~reset;

    // One-hot grant decode back to the requesters.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = w_xfer & (w_win == SRC_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Broadcast register and priority pointer
    // ------------------------------------------------------------------------
    // Flush wins over everything: it kills the next broadcast and restarts
    // priority at unit 0. Without a transfer the payload holds its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio_ptr  <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
        end else if (flush) begin
            r_prio_ptr  <= '0;
            r_cdb_valid <= 1'b0;
        end else if (w_xfer) begin
            r_prio_ptr  <= w_win + SRC_W'(1);
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= w_tag_arr[w_win];
            r_cdb_data  <= w_data_arr[w_win];
            r_cdb_src   <= w_win;
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign cdb_src   = r_cdb_src;

    // ------------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    // Grant is never more than one-hot.
    a_onehot_grant : assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_ready));

    // Stall or flush blocks every grant.
    a_no_grant_blocked : assert property (@(posedge clk) disable iff (reset)
        (stall || flush) |-> (req_ready == '0));

    // Grants only go to valid requesters.
    a_grant_valid : assert property (@(posedge clk) disable iff (reset)
        ((req_ready & ~req_valid) == '0));

    // An accepted result is broadcast on the following cycle.
    a_broadcast_latency : assert property (@(posedge clk) disable iff (reset)
        (|(req_valid & req_ready)) |=> cdb_valid);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_rr_arbiter
//  Description : Directed self-checking bench for cdb_rr_arbiter (N_REQ=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_rr_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int SRC_W  = 2;

    logic                     clk;
    logic                     reset;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*TAG_W-1:0]   req_tag;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]         req_ready;
    logic                     stall;
    logic                     flush;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [SRC_W-1:0]         cdb_src;

    // Fixed per-unit payloads; expected broadcast payload is looked up here.
    logic [TAG_W-1:0]  c_tag  [N_REQ];
    logic [DATA_W-1:0] c_data [N_REQ];

    int checks;
    int errors;

    cdb_rr_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .stall     (stall),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of request inputs (just after a rising edge), check the
    // combinational grant, then advance to just after the next rising edge.
    task automatic drive(input string tag, input logic [3:0] v, input logic st,
                         input logic fl, input logic [3:0] exp_rdy);
        req_valid = v;
        stall     = st;
        flush     = fl;
        #1;
        check({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    // Check the registered broadcast against the payload of unit src.
    task automatic check_cdb(input string tag, input logic v, input int src);
        check({tag, "_valid"}, 64'(cdb_valid), 64'(v));
        check({tag, "_tag"},   64'(cdb_tag),   64'(c_tag[src]));
        check({tag, "_data"},  64'(cdb_data),  64'(c_data[src]));
        check({tag, "_src"},   64'(cdb_src),   64'(src));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        c_tag[0] = 6'h01; c_data[0] = 32'h1111_0000;
        c_tag[1] = 6'h0A; c_data[1] = 32'h2222_1111;
        c_tag[2] = 6'h15; c_data[2] = 32'hDEAD_BEEF;
        c_tag[3] = 6'h3F; c_data[3] = 32'hCAFE_F00D;
        for (int i = 0; i < N_REQ; i++) begin
            req_tag[i*TAG_W +: TAG_W]    = c_tag[i];
            req_data[i*DATA_W +: DATA_W] = c_data[i];
        end
        reset     = 1'b1;
        req_valid = 4'b1111;
        stall     = 1'b0;
        flush     = 1'b0;

        // Reset state: no grant even with requests pending.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_valid", 64'(cdb_valid), 64'h0);
        check("rst_tag",   64'(cdb_tag),   64'h0);
        check("rst_data",  64'(cdb_data),  64'h0);
        check("rst_src",   64'(cdb_src),   64'h0);
        reset = 1'b0;

        // Single requester (unit 2): grant, then broadcast one cycle later.
        drive("u2", 4'b0100, 1'b0, 1'b0, 4'b0100);
        check_cdb("u2_cdb", 1'b1, 2);                 // ptr -> 3
        drive("idle", 4'b0000, 1'b0, 1'b0, 4'b0000);
        check_cdb("idle_hold", 1'b0, 2);              // payload holds

        // All valid from ptr=3: 3 then 0,1,2,3,0,1 back to back.
        drive("all_a", 4'b1111, 1'b0, 1'b0, 4'b1000);
        check_cdb("all_a_cdb", 1'b1, 3);              // ptr -> 0
        drive("rr0", 4'b1111, 1'b0, 1'b0, 4'b0001);
        check_cdb("rr0_cdb", 1'b1, 0);
        drive("rr1", 4'b1111, 1'b0, 1'b0, 4'b0010);
        check_cdb("rr1_cdb", 1'b1, 1);
        drive("rr2", 4'b1111, 1'b0, 1'b0, 4'b0100);
        check_cdb("rr2_cdb", 1'b1, 2);
        drive("rr3", 4'b1111, 1'b0, 1'b0, 4'b1000);
        check_cdb("rr3_cdb", 1'b1, 3);
        drive("rr4", 4'b1111, 1'b0, 1'b0, 4'b0001);
        check_cdb("rr4_cdb", 1'b1, 0);
        drive("rr5", 4'b1111, 1'b0, 1'b0, 4'b0010);
        check_cdb("rr5_cdb", 1'b1, 1);                // ptr -> 2

        // Flush with ptr=2, units 2,3 valid: registered broadcast still
        // visible during the flush cycle, killed the cycle after; ptr -> 0.
        check("fl_pending_valid", 64'(cdb_valid), 64'h1);
        drive("fl", 4'b1100, 1'b0, 1'b1, 4'b0000);
        check_cdb("fl_cdb", 1'b0, 1);
        drive("fl_after", 4'b1010, 1'b0, 1'b0, 4'b0010);  // ptr=0 -> unit 1
        check_cdb("fl_after_cdb", 1'b1, 1);           // ptr -> 2
        drive("fl_u23", 4'b1100, 1'b0, 1'b0, 4'b0100);
        check_cdb("fl_u23_cdb", 1'b1, 2);             // ptr -> 3

        // Flush overrides stall and still clears the pointer.
        drive("fl_st", 4'b1111, 1'b1, 1'b1, 4'b0000);
        check_cdb("fl_st_cdb", 1'b0, 2);
        drive("fl_st_after", 4'b1111, 1'b0, 1'b0, 4'b0001);
        check_cdb("fl_st_after_cdb", 1'b1, 0);        // ptr -> 1

        // valid={1,0,0,1} from ptr=1: grant 3, wrap to 0, then 3 again.
        drive("w3", 4'b1001, 1'b0, 1'b0, 4'b1000);
        check_cdb("w3_cdb", 1'b1, 3);                 // ptr -> 0
        drive("w0", 4'b1001, 1'b0, 1'b0, 4'b0001);
        check_cdb("w0_cdb", 1'b1, 0);                 // ptr -> 1
        drive("w3b", 4'b1001, 1'b0, 1'b0, 4'b1000);
        check_cdb("w3b_cdb", 1'b1, 3);                // ptr -> 0

        // Stall three cycles with unit 1 valid, then grant 1.
        for (int i = 0; i < 3; i++) begin
            drive("st", 4'b0010, 1'b1, 1'b0, 4'b0000);
            check_cdb("st_cdb", 1'b0, 3);
        end
        drive("st_rel", 4'b0010, 1'b0, 1'b0, 4'b0010);
        check_cdb("st_rel_cdb", 1'b1, 1);             // ptr -> 2

        // Reset mid-broadcast: outputs clear immediately, ptr back to 0.
        drive("pre_rst", 4'b1111, 1'b0, 1'b0, 4'b0100);
        check_cdb("pre_rst_cdb", 1'b1, 2);            // ptr -> 3
        reset     = 1'b1;
        req_valid = 4'b1010;
        #1;
        check("mid_rst_valid", 64'(cdb_valid), 64'h0);
        check("mid_rst_tag",   64'(cdb_tag),   64'h0);
        check("mid_rst_data",  64'(cdb_data),  64'h0);
        check("mid_rst_src",   64'(cdb_src),   64'h0);
        check("mid_rst_ready", 64'(req_ready), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive("post_rst", 4'b1010, 1'b0, 1'b0, 4'b0010);  // lowest valid from 0
        check_cdb("post_rst_cdb", 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
